// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch path: state encoding,
// reset PC, sequential increment and instruction width.
package cpu_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } if_state_e;

endpackage

// File: rtl/pc_incrementer.sv
// Combinational next-PC: PC+4, optionally plus a word offset.
// All arithmetic wraps modulo 2^32.
module pc_incrementer
  import cpu_pkg::*;
(
  input  logic [31:0] PC,
  input  logic        PC_sel,
  input  logic [31:0] PC_Immed,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc;
  logic [31:0] offset;
  logic [31:0] sum;

  // Shifting inside a 32-bit expression drops PC_Immed[31:30]; the mask keeps the PC word aligned.
  always_comb begin
    seq_pc  = PC + PC_INC;
    offset  = PC_Immed << 2;
    sum     = PC_sel ? (seq_pc + offset) : seq_pc;
    next_pc = sum & 32'hFFFF_FFFC;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: requests a word at PC, latches it into Instr,
// then holds it until the control unit accepts it and the PC advances.
module if_stage
  import cpu_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  input  logic               PC_sel,
  input  logic [31:0]        PC_Immed,
  input  logic               PC_LdEn,
  output logic               Mem_req,
  output logic [31:0]        Mem_addr,
  input  logic               Mem_ack,
  input  logic [INSTR_W-1:0] Mem_data,
  output logic [INSTR_W-1:0] Instr,
  output logic               Instr_valid,
  output logic [31:0]        PC
);

  if_state_e          state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        next_pc;

  pc_incrementer u_pc_inc (
    .PC       (pc_q),
    .PC_sel   (PC_sel),
    .PC_Immed (PC_Immed),
    .next_pc  (next_pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      pc_q      <= PC_RESET;
      instr_q   <= '0;
      valid_q   <= 1'b0;
      mem_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      valid_q   <= valid_d;
      mem_req_q <= mem_req_d;
    end
  end

  // Mem_ack only matters in FETCH and PC_LdEn only in READY; elsewhere they fall through to hold.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    valid_d   = valid_q;
    mem_req_d = mem_req_q;
    case (state_q)
      IDLE: begin
        state_d   = FETCH;
        mem_req_d = 1'b1;
        valid_d   = 1'b0;
      end
      FETCH: begin
        mem_req_d = 1'b1;
        valid_d   = 1'b0;
        if (Mem_ack) begin
          instr_d   = Mem_data;
          mem_req_d = 1'b0;
          valid_d   = 1'b1;
          state_d   = READY;
        end
      end
      READY: begin
        mem_req_d = 1'b0;
        if (PC_LdEn) begin
          pc_d      = next_pc;
          valid_d   = 1'b0;
          mem_req_d = 1'b1;
          state_d   = FETCH;
        end
      end
      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
        valid_d   = 1'b0;
      end
    endcase
  end

  assign Mem_req     = mem_req_q;
  assign Mem_addr    = pc_q;
  assign PC          = pc_q;
  assign Instr       = instr_q;
  assign Instr_valid = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: every acknowledged fetch queues its expected
// {PC, Instr}; a monitor pops and compares on each rising Instr_valid.
module tb_if_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PC_sel;
  logic [31:0] PC_Immed;
  logic        PC_LdEn;
  logic        Mem_req;
  logic [31:0] Mem_addr;
  logic        Mem_ack;
  logic [31:0] Mem_data;
  logic [31:0] Instr;
  logic        Instr_valid;
  logic [31:0] PC;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];
  logic [31:0] cur_pc;
  logic [31:0] last_instr;
  logic        prev_valid = 1'b0;

  if_stage dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .PC_sel      (PC_sel),
    .PC_Immed    (PC_Immed),
    .PC_LdEn     (PC_LdEn),
    .Mem_req     (Mem_req),
    .Mem_addr    (Mem_addr),
    .Mem_ack     (Mem_ack),
    .Mem_data    (Mem_data),
    .Instr       (Instr),
    .Instr_valid (Instr_valid),
    .PC          (PC)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Monitor: each new valid instruction must match the oldest queued expectation.
  always @(negedge Clk) begin
    if (Instr_valid === 1'b1 && prev_valid === 1'b0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got instr %h pc %h expected no delivery", Instr, PC);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        chk("sb_pc", PC, e[63:32]);
        chk("sb_instr", Instr, e[31:0]);
      end
    end
    prev_valid <= Instr_valid;
  end

  task automatic advance(input logic sel, input logic [31:0] imm, input logic [31:0] exp_pc);
    PC_LdEn  = 1'b1;
    PC_sel   = sel;
    PC_Immed = imm;
    tick();
    PC_LdEn  = 1'b0;
    PC_sel   = ~sel;
    PC_Immed = 32'hA5A5_A5A5;
    chk("adv_pc", PC, exp_pc);
    chk("adv_addr", Mem_addr, exp_pc);
    chk("adv_req", {31'd0, Mem_req}, 32'd1);
    chk("adv_valid", {31'd0, Instr_valid}, 32'd0);
    cur_pc = exp_pc;
  endtask

  task automatic fetch(input logic [31:0] data, input int waits);
    for (int i = 0; i < waits; i++) begin
      PC_LdEn = i[0];
      PC_sel  = 1'b1;
      tick();
      chk("wait_req", {31'd0, Mem_req}, 32'd1);
      chk("wait_addr", Mem_addr, cur_pc);
      chk("wait_pc", PC, cur_pc);
      chk("wait_instr", Instr, last_instr);
      chk("wait_valid", {31'd0, Instr_valid}, 32'd0);
    end
    PC_LdEn  = 1'b0;
    Mem_ack  = 1'b1;
    Mem_data = data;
    sb_q.push_back({cur_pc, data});
    tick();
    Mem_ack  = 1'b0;
    Mem_data = 32'hDEAD_0000;
    chk("ack_req", {31'd0, Mem_req}, 32'd0);
    chk("ack_valid", {31'd0, Instr_valid}, 32'd1);
    last_instr = data;
  endtask

  initial begin
    Reset    = 1'b1;
    PC_sel   = 1'b0;
    PC_Immed = 32'd0;
    PC_LdEn  = 1'b0;
    Mem_ack  = 1'b0;
    Mem_data = 32'd0;
    repeat (3) tick();
    chk("rst_req", {31'd0, Mem_req}, 32'd0);
    chk("rst_pc", PC, 32'h0000_0000);
    chk("rst_instr", Instr, 32'h0000_0000);
    chk("rst_valid", {31'd0, Instr_valid}, 32'd0);

    // First fetch with ack held from reset release: IDLE, then one FETCH cycle.
    Reset    = 1'b0;
    Mem_ack  = 1'b1;
    Mem_data = 32'h2001_0005;
    tick();
    chk("first_req", {31'd0, Mem_req}, 32'd1);
    chk("first_addr", Mem_addr, 32'h0000_0000);
    chk("first_valid", {31'd0, Instr_valid}, 32'd0);
    sb_q.push_back({32'h0000_0000, 32'h2001_0005});
    tick();
    Mem_ack = 1'b0;
    chk("first_lat_valid", {31'd0, Instr_valid}, 32'd1);
    chk("first_lat_req", {31'd0, Mem_req}, 32'd0);
    cur_pc     = 32'h0000_0000;
    last_instr = 32'h2001_0005;

    // Ack while READY must not disturb the held instruction.
    Mem_ack  = 1'b1;
    Mem_data = 32'hDEAD_BEEF;
    repeat (2) tick();
    Mem_ack  = 1'b0;
    chk("ready_ack_instr", Instr, 32'h2001_0005);
    chk("ready_ack_valid", {31'd0, Instr_valid}, 32'd1);
    chk("ready_ack_req", {31'd0, Mem_req}, 32'd0);

    advance(1'b0, 32'd0,          32'h0000_0004); fetch(32'h1111_0004, 0);
    advance(1'b0, 32'h0000_0100,  32'h0000_0008); fetch(32'h1111_0008, 1);
    advance(1'b0, 32'd0,          32'h0000_000C); fetch(32'h1111_000C, 0);
    advance(1'b0, 32'd0,          32'h0000_0010); fetch(32'h1111_0010, 0);
    advance(1'b0, 32'd0,          32'h0000_0014); fetch(32'h1111_0014, 0);
    advance(1'b1, 32'hFFFF_FFFB,  32'h0000_0004); fetch(32'h2222_0004, 0);
    advance(1'b1, 32'h0000_0002,  32'h0000_0010); fetch(32'h2222_0010, 0);
    advance(1'b1, 32'hFFFF_FFFD,  32'h0000_0008); fetch(32'h3333_0008, 0);
    advance(1'b1, 32'hFFFF_FFFC,  32'hFFFF_FFFC); fetch(32'h3333_FFFC, 0);
    advance(1'b0, 32'd0,          32'h0000_0000); fetch(32'h4444_0000, 0);
    advance(1'b1, 32'h4000_0001,  32'h0000_0008); fetch(32'h5555_0008, 5);

    // Abort a pending fetch with reset; an ack right after release is ignored.
    advance(1'b0, 32'd0, 32'h0000_000C);
    Reset = 1'b1;
    #1;
    chk("async_req", {31'd0, Mem_req}, 32'd0);
    chk("async_pc", PC, 32'h0000_0000);
    chk("async_instr", Instr, 32'h0000_0000);
    chk("async_valid", {31'd0, Instr_valid}, 32'd0);
    tick();
    Reset    = 1'b0;
    Mem_ack  = 1'b1;
    Mem_data = 32'h1234_4321;
    tick();
    Mem_ack  = 1'b0;
    chk("post_rst_instr", Instr, 32'h0000_0000);
    chk("post_rst_valid", {31'd0, Instr_valid}, 32'd0);
    chk("post_rst_req", {31'd0, Mem_req}, 32'd1);
    chk("post_rst_addr", Mem_addr, 32'h0000_0000);
    cur_pc     = 32'h0000_0000;
    last_instr = 32'h0000_0000;
    fetch(32'h0C00_FFEE, 2);

    repeat (3) tick();
    chk("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL use one clock and reset: asynchronous, active-high reset; clock port Clk, reset port Reset.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  async active-high reset.
REQ-004 PC_sel  input  1  0: next PC = PC+4; 1: next PC = PC+4+(PC_Immed<<2).
REQ-005 PC_Immed  input  32  sign-extended word offset from decode.
REQ-006 PC_LdEn  input  1  control unit accepts current Instr and advances PC.
REQ-007 Mem_req  output  1  instruction-memory read request, registered.
REQ-008 Mem_addr  output  32  byte address of fetch, equals PC.
REQ-009 Mem_ack  input  1  memory returns Mem_data this cycle.
REQ-010 Mem_data  input  32  instruction word from memory.
REQ-011 Instr  output  32  instruction register feeding decode.
REQ-012 Instr_valid  output  1  Instr holds a fetched, unconsumed instruction.
REQ-013 PC  output  32  current program counter.

Function
REQ-014 FSM states SHALL be IDLE, FETCH, READY; all outputs registered.
REQ-015 IDLE -> FETCH unconditionally on first Clk edge after Reset deasserts.
REQ-016 FETCH: Mem_req=1, Mem_addr=PC held stable, Instr_valid=0.
REQ-017 FETCH with Mem_ack=1 at edge: Instr <= Mem_data, Mem_req <= 0, Instr_valid <= 1, -> READY; Mem_ack=0 waits indefinitely.
REQ-018 READY: Mem_req=0, Instr/Instr_valid held until PC_LdEn=1.
REQ-019 READY with PC_LdEn=1 at edge: PC <= next PC per PC_sel, Instr_valid <= 0, Mem_req <= 1, -> FETCH.
REQ-020 Next PC arithmetic SHALL be 32-bit modulo 2^32 (wraps, no flag); PC_Immed<<2 discards top two bits.
REQ-021 PC[1:0] SHALL always be 00.
REQ-022 Mem_ack outside FETCH SHALL be ignored; PC_LdEn outside READY SHALL be ignored.
REQ-023 Instr SHALL keep its last value during FETCH (not cleared).
REQ-024 Minimum fetch latency: Mem_req high to Instr_valid high = 1 cycle when Mem_ack returns on first request cycle.
REQ-025 PC_sel and PC_Immed SHALL be sampled only on the PC_LdEn edge.

Reset
REQ-026 Reset SHALL immediately force: state IDLE, PC=0x00000000, Instr=0x00000000, Instr_valid=0, Mem_req=0.
REQ-027 Reset mid-FETCH SHALL abort the request; a later Mem_ack SHALL not load Instr.
REQ-028 After Reset, first fetch SHALL be from address 0x00000000.

Structure
REQ-029 Shared package cpu_pkg SHALL hold FSM state encoding, PC_RESET (0x00000000), PC_INC (4), instruction width (32).
REQ-030 Next-PC computation SHALL be a combinational sub-module pc_incrementer (inputs PC, PC_sel, PC_Immed; output next PC).

Verification
REQ-031 Reset then Mem_ack=1 immediately, Mem_data=0x20010005 -> Mem_addr=0x0, Instr=0x20010005, Instr_valid=1 one cycle after Mem_req rose.
REQ-032 READY, PC=0x10, PC_LdEn=1, PC_sel=0 -> PC=0x14, Mem_addr=0x14, Instr_valid=0 next cycle.
REQ-033 PC=0x10, PC_sel=1, PC_Immed=0xFFFFFFFD -> PC=0x08; PC=0xFFFFFFFC, PC_sel=0 -> PC=0x00 (wrap).
REQ-034 FETCH with Mem_ack low 5 cycles, PC_LdEn pulsed meanwhile -> Mem_req stays 1, Mem_addr stable, PC unchanged, Instr unchanged until ack.
REQ-035 Reset asserted during FETCH, Mem_ack=1 one cycle after release -> Instr=0x0, Instr_valid=0, state IDLE then FETCH at 0x0.
REQ-036 Mem_ack=1 while READY with Mem_data=0xDEADBEEF -> Instr unchanged, Instr_valid stays 1.
